// File: rtl/canny_pkg.sv
// Shared types and helpers for the Canny edge pipeline stages.
// Contents:
//   state_t      streaming stage state (FILL / RUN / FLUSH)
//   pixel_t      8-bit pixel
//   mag_t        signed/unsigned 11-bit gradient intermediate
//   kernel_sum   one-sided Sobel weighted sum (1,2,1)
//   abs_val      two's-complement magnitude of an 11-bit value
//   saturate     clamp an 11-bit magnitude to the pixel range
package canny_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef logic [7:0] pixel_t;

    localparam int MAG_W = 11;
    typedef logic [MAG_W-1:0] mag_t;

    localparam int SOBEL_SIDE_WEIGHT   = 1;
    localparam int SOBEL_CENTRE_WEIGHT = 2;
    localparam int PIXEL_MAX           = 255;

    // Weighted column/row sum a + 2b + c; max 1020, fits in MAG_W bits.
    function automatic mag_t kernel_sum(input pixel_t a, input pixel_t b, input pixel_t c);
        return mag_t'(int'(a) * SOBEL_SIDE_WEIGHT
                    + int'(b) * SOBEL_CENTRE_WEIGHT
                    + int'(c) * SOBEL_SIDE_WEIGHT);
    endfunction

    function automatic mag_t abs_val(input mag_t v);
        return v[MAG_W-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic pixel_t saturate(input mag_t m);
        return (m > mag_t'(PIXEL_MAX)) ? 8'hFF : m[7:0];
    endfunction

endpackage

// File: rtl/line_window_3x3.sv
// 3x3 sliding window over a raster pixel stream.
// The newest pixel (din) is the bottom-right tap directly, so the window is
// valid in the same cycle that pixel is presented; only 2*WIDTH+2 older
// pixels are stored.
// Ports:
//   clock     rising-edge clock
//   reset     asynchronous active-low, clears stored pixels
//   shift_en  push din into the line store this cycle
//   din       incoming pixel
//   tap_RC    window taps, R = row (0 top), C = column (0 left)
module line_window_3x3 #(
    parameter int WIDTH = 1280
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       shift_en,
    input  logic [7:0] din,
    output logic [7:0] tap_00,
    output logic [7:0] tap_01,
    output logic [7:0] tap_02,
    output logic [7:0] tap_10,
    output logic [7:0] tap_11,
    output logic [7:0] tap_12,
    output logic [7:0] tap_20,
    output logic [7:0] tap_21,
    output logic [7:0] tap_22
);

    localparam int LEN = 2 * WIDTH + 2;

    // sr_reg[k] holds the pixel that arrived k+1 shifts ago.
    logic [7:0] sr_reg [0:LEN-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LEN; i++) begin
                sr_reg[i] <= 8'd0;
            end
        end else if (shift_en) begin
            sr_reg[0] <= din;
            for (int i = 1; i < LEN; i++) begin
                sr_reg[i] <= sr_reg[i-1];
            end
        end
    end

    assign tap_22 = din;
    assign tap_21 = sr_reg[0];
    assign tap_20 = sr_reg[1];
    assign tap_12 = sr_reg[WIDTH-1];
    assign tap_11 = sr_reg[WIDTH];
    assign tap_10 = sr_reg[WIDTH+1];
    assign tap_02 = sr_reg[2*WIDTH-1];
    assign tap_01 = sr_reg[2*WIDTH];
    assign tap_00 = sr_reg[2*WIDTH+1];

endmodule

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel gradient-magnitude stage.
// Pops blurred pixels from an FWFT FIFO and pushes one saturated magnitude per
// pixel, raster order. FILL primes WIDTH+1 pixels, RUN is 1-in/1-out, FLUSH
// drains the last WIDTH+1 (border) outputs without reading.
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   in_rd_en   pop upstream FIFO (in_dout valid same cycle)
//   in_empty   upstream FIFO empty
//   in_dout    upstream pixel
//   out_wr_en  push downstream FIFO
//   out_full   downstream FIFO full
//   out_din    gradient magnitude (0 when not writing)
module sobel_filter #(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 720
) (
    input  logic       clock,
    input  logic       reset,
    output logic       in_rd_en,
    input  logic       in_empty,
    input  logic [7:0] in_dout,
    output logic       out_wr_en,
    input  logic       out_full,
    output logic [7:0] out_din
);
    import canny_pkg::*;

    localparam int FRAME_PIX = WIDTH * HEIGHT;
    localparam int RD_W      = $clog2(FRAME_PIX + 1);
    localparam int FL_W      = $clog2(WIDTH + 2);
    localparam int ROW_W     = $clog2(HEIGHT);
    localparam int COL_W     = $clog2(WIDTH);

    state_t           state_reg, state_next;
    logic [RD_W-1:0]  rd_cnt_reg;
    logic [FL_W-1:0]  fl_cnt_reg;
    logic [ROW_W-1:0] out_row_reg;
    logic [COL_W-1:0] out_col_reg;

    logic   shift_en;
    pixel_t win_din;
    pixel_t p00, p01, p02, p10, p11, p12, p20, p21, p22;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            FILL:    if (in_rd_en && rd_cnt_reg == RD_W'(WIDTH)) state_next = RUN;
            RUN:     if (in_rd_en && rd_cnt_reg == RD_W'(FRAME_PIX - 1)) state_next = FLUSH;
            FLUSH:   if (out_wr_en && fl_cnt_reg == FL_W'(WIDTH)) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // Outputs; enables are held low for as long as reset is asserted.
    always_comb begin
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        unique case (state_reg)
            FILL:    in_rd_en = !in_empty;
            RUN: begin
                in_rd_en  = !in_empty && !out_full;
                out_wr_en = !in_empty && !out_full;
            end
            FLUSH:   out_wr_en = !out_full;
            default: ;
        endcase
        if (!reset) begin
            in_rd_en  = 1'b0;
            out_wr_en = 1'b0;
        end
    end

    // Flush slots shift zeros so the tail of the frame still advances the window.
    assign shift_en = in_rd_en || out_wr_en;
    assign win_din  = (state_reg == FLUSH) ? 8'd0 : in_dout;

    // Frame counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_cnt_reg  <= '0;
            fl_cnt_reg  <= '0;
            out_row_reg <= '0;
            out_col_reg <= '0;
        end else begin
            if (in_rd_en) begin
                rd_cnt_reg <= rd_cnt_reg + 1'b1;
            end
            if (state_reg == FLUSH && out_wr_en) begin
                if (fl_cnt_reg == FL_W'(WIDTH)) begin
                    fl_cnt_reg <= '0;
                    rd_cnt_reg <= '0;
                end else begin
                    fl_cnt_reg <= fl_cnt_reg + 1'b1;
                end
            end
            if (out_wr_en) begin
                if (out_col_reg == COL_W'(WIDTH - 1)) begin
                    out_col_reg <= '0;
                    out_row_reg <= (out_row_reg == ROW_W'(HEIGHT - 1)) ? '0 : out_row_reg + 1'b1;
                end else begin
                    out_col_reg <= out_col_reg + 1'b1;
                end
            end
        end
    end

    line_window_3x3 #(.WIDTH(WIDTH)) u_window (
        .clock    (clock),
        .reset    (reset),
        .shift_en (shift_en),
        .din      (win_din),
        .tap_00   (p00),
        .tap_01   (p01),
        .tap_02   (p02),
        .tap_10   (p10),
        .tap_11   (p11),
        .tap_12   (p12),
        .tap_20   (p20),
        .tap_21   (p21),
        .tap_22   (p22)
    );

    // Gradient arithmetic. Row-wrapped taps only reach border positions,
    // which the mask forces to zero.
    mag_t gx, gy, grad_sum, mag;
    logic border;

    assign gx       = kernel_sum(p02, p12, p22) - kernel_sum(p00, p10, p20);
    assign gy       = kernel_sum(p20, p21, p22) - kernel_sum(p00, p01, p02);
    assign grad_sum = abs_val(gx) + abs_val(gy);
    assign mag      = grad_sum >> 1;

    assign border = (out_row_reg == '0) || (out_row_reg == ROW_W'(HEIGHT - 1))
                 || (out_col_reg == '0) || (out_col_reg == COL_W'(WIDTH - 1));

    assign out_din = (out_wr_en && !border) ? saturate(mag) : 8'd0;

endmodule

// File: tb/tb_sobel_filter.sv
module tb_sobel_filter;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_rd_en;
    logic       in_empty;
    logic [7:0] in_dout;
    logic       out_wr_en;
    logic       out_full;
    logic [7:0] out_din;

    always #5 clock = ~clock;

    sobel_filter #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_rd_en  (in_rd_en),
        .in_empty  (in_empty),
        .in_dout   (in_dout),
        .out_wr_en (out_wr_en),
        .out_full  (out_full),
        .out_din   (out_din)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] in_q  [$];
    logic [7:0] exp_q [$];
    int         img   [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int px(input int r, input int c);
        return img[r*W + c];
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Build one frame, queue it upstream, and queue its reference magnitudes.
    task automatic load_frame(input int mode);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (mode)
                    0:       img[r*W + c] = 100;
                    1:       img[r*W + c] = (c < 4) ? 0 : 255;
                    2:       img[r*W + c] = (r < 3) ? 0 : 10;
                    default: img[r*W + c] = int'($urandom_range(255));
                endcase
                in_q.push_back(8'(img[r*W + c]));
            end
        end
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int gx, gy, m;
                if (r == 0 || r == H-1 || c == 0 || c == W-1) begin
                    m = 0;
                end else begin
                    gx = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1))
                       - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
                    gy = (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1))
                       - (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1));
                    m  = (iabs(gx) + iabs(gy)) / 2;
                    if (m > 255) m = 255;
                end
                exp_q.push_back(8'(m));
            end
        end
    endtask

    // Drive the FIFO models until n_out writes (or stop_reads reads) happen.
    task automatic run(input string name, input int p_empty, input int p_full,
                       input int n_out, input int stop_reads);
        int writes = 0;
        int reads  = 0;
        int cycles = 0;
        while (writes < n_out && cycles < 5000 && !(stop_reads > 0 && reads >= stop_reads)) begin
            @(negedge clock);
            cycles++;
            in_empty = (in_q.size() == 0) || ($urandom_range(99) < p_empty);
            in_dout  = (in_q.size() != 0) ? in_q[0] : 8'($urandom_range(255));
            out_full = ($urandom_range(99) < p_full);
            #1;
            check({name, "_rd_while_empty"}, 32'(in_rd_en & in_empty), 32'd0);
            check({name, "_wr_while_full"}, 32'(out_wr_en & out_full), 32'd0);
            if (in_rd_en === 1'b1 && !in_empty) begin
                void'(in_q.pop_front());
                reads++;
            end
            if (out_wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check({name, "_unexpected_write"}, 32'(out_wr_en), 32'd0);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check({name, "_pix"}, 32'(out_din), 32'(e));
                end
                writes++;
                if (writes % N == 0)
                    $display("%s: frame %0d complete, %0d writes, cycle %0d", name, writes / N, writes, cycles);
            end
        end
        if (stop_reads == 0) begin
            check({name, "_writes"}, 32'(writes), 32'(n_out));
            check({name, "_input_left"}, 32'(in_q.size()), 32'd0);
        end
        $display("%s: run ended after %0d cycles, %0d reads, %0d writes", name, cycles, reads, writes);
    endtask

    task automatic idle(input string name, input int n);
        in_empty = 1'b1;
        out_full = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            #1;
            check({name, "_idle_wr"}, 32'(out_wr_en), 32'd0);
            check({name, "_idle_rd"}, 32'(in_rd_en), 32'd0);
        end
    endtask

    initial begin
        reset    = 1'b0;
        in_empty = 1'b1;
        out_full = 1'b0;
        in_dout  = 8'd0;
        repeat (3) @(negedge clock);
        // Reset state with upstream data available
        in_empty = 1'b0;
        in_dout  = 8'd77;
        #1;
        check("reset_rd_en", 32'(in_rd_en), 32'd0);
        check("reset_wr_en", 32'(out_wr_en), 32'd0);
        check("reset_dout", 32'(out_din), 32'd0);
        @(negedge clock);
        in_empty = 1'b1;
        reset    = 1'b1;

        // 1 flat frame
        load_frame(0);
        run("t1_flat", 0, 0, N, 0);
        idle("t1", 4);

        // 2 vertical edge
        load_frame(1);
        run("t2_vedge", 0, 0, N, 0);
        idle("t2", 4);

        // 3 horizontal step
        load_frame(2);
        run("t3_hstep", 0, 0, N, 0);
        idle("t3", 4);

        // 4 random pixels with random stalls on both sides
        load_frame(3);
        run("t4_stall", 30, 30, N, 0);
        idle("t4", 4);

        // 5 three back-to-back frames
        load_frame(3);
        load_frame(3);
        load_frame(3);
        run("t5_b2b", 0, 0, 3*N, 0);
        idle("t5", 4);

        // 6 reset during row 3, then a clean frame
        load_frame(3);
        run("t6_abort", 20, 20, N, 3*W + 4);
        @(negedge clock);
        reset    = 1'b0;
        in_empty = 1'b0;
        out_full = 1'b0;
        in_dout  = 8'd200;
        #1;
        check("t6_reset_rd_en", 32'(in_rd_en), 32'd0);
        check("t6_reset_wr_en", 32'(out_wr_en), 32'd0);
        check("t6_reset_dout", 32'(out_din), 32'd0);
        in_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clock);
        in_empty = 1'b1;
        reset    = 1'b1;
        load_frame(3);
        run("t6_clean", 10, 10, N, 0);
        idle("t6", 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
